// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper
//   Sequencer/checker for a small combinational boolean-expression block.
//   On start, walks every input vector 0 .. 2^N_IN-1 in ascending order,
//   holds each one for SETTLE cycles, samples the block's output in a
//   following one-cycle SAMPLE state and compares it with EXPECT_MASK.
//
// Ports
//   clk             rising-edge clock
//   rst_n           asynchronous reset, active low
//   start           begin a sweep (honoured only when idle)
//   abort           stop a running sweep, return to idle without done
//   dut_out         output of the block being swept
//   vec             input vector driven to the block ({x,y,w,z} for N_IN=4)
//   busy            high while a sweep is in progress
//   done            one-cycle pulse when a sweep completes
//   pass            1 when the completed sweep saw no mismatch
//   err_count       number of mismatching vectors
//   first_err_idx   index of the first mismatch (0 if none)
//   first_err_valid a mismatch has been recorded in this sweep
//   table_out       captured outputs, bit i = dut_out sampled for vec=i

module truth_table_sweeper #(
  parameter int                     N_IN        = 4,
  parameter int                     SETTLE      = 1,
  parameter logic [(1<<N_IN)-1:0]   EXPECT_MASK = 16'h230D
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   dut_out,
  output logic [N_IN-1:0]        vec,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [N_IN:0]          err_count,
  output logic [N_IN-1:0]        first_err_idx,
  output logic                   first_err_valid,
  output logic [(1<<N_IN)-1:0]   table_out
);

  localparam int NV    = 1 << N_IN;
  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  // The counter is loaded with SETTLE-1 and the exit taken at zero, so a
  // vector spends exactly SETTLE cycles in SETTLE before its SAMPLE cycle.
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(SETTLE - 1);
  localparam logic [N_IN-1:0]  VEC_LAST   = N_IN'(NV - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [N_IN-1:0]    vec_n;
  logic               busy_n;
  logic               done_n;
  logic               pass_n;
  logic [N_IN:0]      err_n;
  logic [N_IN-1:0]    fidx_n;
  logic               fvld_n;
  logic [NV-1:0]      table_n;
  logic               mismatch;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ST_IDLE;
      cnt             <= '0;
      vec             <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      err_count       <= '0;
      first_err_idx   <= '0;
      first_err_valid <= 1'b0;
      table_out       <= '0;
    end else begin
      state           <= state_n;
      cnt             <= cnt_n;
      vec             <= vec_n;
      busy            <= busy_n;
      done            <= done_n;
      pass            <= pass_n;
      err_count       <= err_n;
      first_err_idx   <= fidx_n;
      first_err_valid <= fvld_n;
      table_out       <= table_n;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    vec_n    = vec;
    busy_n   = busy;
    done_n   = 1'b0;
    pass_n   = pass;
    err_n    = err_count;
    fidx_n   = first_err_idx;
    fvld_n   = first_err_valid;
    table_n  = table_out;
    mismatch = (dut_out != EXPECT_MASK[vec]);

    case (state)
      ST_IDLE: begin
        // abort outranks start when both arrive together.
        if (start && !abort) begin
          state_n = ST_SETTLE;
          vec_n   = '0;
          cnt_n   = CNT_RELOAD;
          busy_n  = 1'b1;
          pass_n  = 1'b0;
          err_n   = '0;
          fidx_n  = '0;
          fvld_n  = 1'b0;
          table_n = '0;
        end
      end

      ST_SETTLE: begin
        if (abort) begin
          state_n = ST_IDLE;
          busy_n  = 1'b0;
        end else if (cnt != '0) begin
          cnt_n = cnt - 1'b1;
        end else begin
          state_n = ST_SAMPLE;
        end
      end

      ST_SAMPLE: begin
        // An abort on the sampling edge discards that vector's capture.
        if (abort) begin
          state_n = ST_IDLE;
          busy_n  = 1'b0;
        end else begin
          table_n[vec] = dut_out;
          if (mismatch) begin
            err_n = err_count + 1'b1;
            if (!first_err_valid) begin
              fidx_n = vec;
              fvld_n = 1'b1;
            end
          end
          if (vec == VEC_LAST) begin
            state_n = ST_DONE;
            busy_n  = 1'b0;
            done_n  = 1'b1;
            pass_n  = (err_n == '0);
          end else begin
            vec_n   = vec + 1'b1;
            cnt_n   = CNT_RELOAD;
            state_n = ST_SETTLE;
          end
        end
      end

      ST_DONE: begin
        state_n = ST_IDLE;
      end

      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
- Sequencer/checker for a 4-input combinational boolean-expression block.
- On `start`, drives all 2^N_IN input vectors to the DUT in ascending order (x = MSB … z = LSB).
- After a settle interval, samples the DUT output for each vector, captures it into a truth-table register and compares it against the expected minterm mask.
- Reports pass/fail, mismatch count and first failing index. Replaces hand-written stimulus sequences in expression-block benches and self-test wrappers.

Parameters:
N_IN, 4, number of DUT inputs; vector count is 2^N_IN.
SETTLE, 1, cycles a vector is held before sampling; legal range ≥1.
EXPECT_MASK, 16'h230D, expected output per vector; bit i = expected f(i). Default encodes Σm(0,2,3,8,9,13). Width 2^N_IN.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous reset, active low
start  in  1  begin sweep; accepted only in IDLE
abort  in  1  synchronous abort; returns to IDLE, no done pulse
dut_out  in  1  output of the DUT under sweep
vec  out  N_IN  input vector driven to DUT ({x,y,w,z} for N_IN=4)
busy  out  1  high in SETTLE/SAMPLE
done  out  1  one-cycle pulse when sweep completes
pass  out  1  1 when err_count==0; valid from done, held until next start
err_count  out  N_IN+1  number of mismatching vectors (max 2^N_IN, no overflow)
first_err_idx  out  N_IN  index of first mismatch; 0 if none
first_err_valid  out  1  a mismatch has been recorded this sweep
table_out  out  2^N_IN  captured DUT outputs, bit i = dut_out sampled for vec=i

Behaviour:
- All outputs are registered.
- Reset (rst_n low, async) values: state=IDLE, vec=0, busy=0, done=0, pass=0, err_count=0, first_err_idx=0, first_err_valid=0, table_out=0, settle counter=0.
- Reset mid-sweep aborts immediately with these values.
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - start=1 at edge k → SETTLE; vec=0, settle cnt=SETTLE-1, busy=1.
  - Same edge clears err_count, first_err_*, table_out and pass.
- SETTLE:
  - cnt≠0 → cnt--.
  - cnt==0 → SAMPLE.
  - Lasts exactly SETTLE cycles.
- SAMPLE (one cycle); at the exiting edge:
  - table_out[vec] ← dut_out.
  - If dut_out≠EXPECT_MASK[vec]: err_count++; if first_err_valid==0, first_err_idx←vec and first_err_valid←1.
  - If vec==2^N_IN-1 → DONE, busy=0, pass←(final err_count==0), done=1.
  - Otherwise vec++, cnt←SETTLE-1 → SETTLE.
- DONE: done=1 for this single cycle, then IDLE, done=0. vec holds the last value.
- Timing:
  - Each vector occupies SETTLE+1 cycles.
  - Final capture and done assertion occur at edge k+2^N_IN·(SETTLE+1).
  - For the defaults, done is high in the cycle after edge k+32.
- start while not in IDLE (including the DONE cycle) is ignored; no restart, no counter effect.
- abort=1 in SETTLE/SAMPLE → IDLE next edge:
  - busy=0, no done.
  - Partial table_out/err_count are retained; pass stays 0.
  - abort has priority over a same-edge SAMPLE capture (no capture that edge).
  - abort in IDLE/DONE has no effect.
- start and abort both high in IDLE: abort wins, stay IDLE.
- Outputs hold their values in IDLE until the next accepted start.

Test Plan:
- Defaults, DUT modelled correctly as Σm(0,2,3,8,9,13), start at edge k:
  - vec steps 0..15, each held 2 cycles.
  - done pulse after edge k+32, one cycle wide.
  - pass=1, err_count=0, first_err_valid=0, table_out=16'h230D.
- DUT with minterm 13 stuck at 0:
  - err_count=1, first_err_idx=13, first_err_valid=1.
  - table_out=16'h030D, pass=0.
- Inverted DUT (~f):
  - err_count=16 (5'b10000), first_err_idx=0.
  - table_out=16'hDCF2, pass=0.
- Pulse start again at vec=5 mid-sweep:
  - ignored; sweep and done timing unchanged (done at original k+32).
  - Then abort at vec=7 in a second sweep → busy=0 next edge, no done.
  - table_out bits 0..6 captured, pass=0.
- SETTLE=3 build, correct DUT: each vector held 4 cycles, done after edge k+64, pass=1.
- rst_n driven low asynchronously mid-SETTLE at vec=9: all outputs return to reset values without waiting for a clock edge. After release, a new start runs a full clean sweep.
